// File: rtl/line_pixel_writer.sv
// line_pixel_writer: clips line-generator pixels, maps them to framebuffer addresses and
// writes them through a small FIFO with a req/ack port. Optional build macro: LINE_WRITER_DEDUP_EN.
module line_pixel_writer #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        Xline,
  input  logic [9:0]         Yline,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               pix_valid,
  input  logic               start_mark,
  input  logic               done_mark,
  output logic               pix_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_wr,
  input  logic               mem_ack,
  output logic               busy,
  output logic               line_done,
  output logic [15:0]        pix_count,
  output logic [7:0]         clip_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // One slot stays free for the pixel already sitting in stage 1.
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH - 1);
  localparam logic [10:0]    X_LIM    = 11'(H_RES);
  localparam logic [9:0]     Y_LIM    = 10'(V_RES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [10:0] x, input logic [9:0] y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  logic [1:0]         state;
  logic               line_gen;
  logic [PTR_W:0]     level;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]  addr_mem [FIFO_DEPTH];
  logic [COLOR_W-1:0] data_mem [FIFO_DEPTH];
  logic               gen_mem  [FIFO_DEPTH];

  logic               vld_p1, inr_p1, gen_p1;
  logic [10:0]        x_p1;
  logic [9:0]         y_p1;
  logic [COLOR_W-1:0] color_p1;

  logic fifo_empty, fifo_full, beat, accept, start_acc, gen_in;
  logic push, pop, clipped, dedup_hit;
  logic [ADDR_W-1:0] push_addr;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level >= FULL_LVL);
  assign pix_ready  = reset && !fifo_full && ((state == S_IDLE) || (state == S_COLLECT));
  assign beat       = pix_valid && pix_ready;
  assign start_acc  = beat && start_mark;
  assign accept     = beat && (start_mark || (state == S_COLLECT));
  // Each line carries a tag bit so entries left from a restarted line are not counted.
  assign gen_in     = start_acc ? !line_gen : line_gen;

  assign push_addr  = pix_addr(x_p1, y_p1);
  assign clipped    = vld_p1 && !inr_p1;

`ifdef LINE_WRITER_DEDUP_EN
  logic              last_vld;
  logic [ADDR_W-1:0] last_addr;
  assign dedup_hit = last_vld && (last_addr == push_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_vld  <= 1'b0;
      last_addr <= '0;
    end else if (start_acc) begin
      last_vld  <= 1'b0;
    end else if (push) begin
      last_vld  <= 1'b1;
      last_addr <= push_addr;
    end
  end
`else
  assign dedup_hit = 1'b0;
`endif

  assign push      = vld_p1 && inr_p1 && !dedup_hit;
  assign mem_wr    = !fifo_empty;
  assign pop       = mem_wr && mem_ack;
  assign mem_addr  = mem_wr ? addr_mem[rd_ptr] : '0;
  assign mem_data  = mem_wr ? data_mem[rd_ptr] : '0;
  assign busy      = (state != S_IDLE);
  assign line_done = (state == S_DONE);

  // ---- stage 1: register coordinate, colour and on-screen flag ----
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p1     <= Xline;
      y_p1     <= Yline;
      color_p1 <= color_in;
      inr_p1   <= (Xline < X_LIM) && (Yline < Y_LIM);
      gen_p1   <= gen_in;
    end
  end

  // ---- stage 2: address computed combinationally, pushed into the FIFO ----
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= color_p1;
      gen_mem[wr_ptr]  <= gen_p1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      line_gen   <= 1'b0;
      vld_p1     <= 1'b0;
      pix_count  <= '0;
      clip_count <= '0;
    end else begin
      vld_p1 <= accept;
      if (start_acc) line_gen <= !line_gen;

      if (start_acc)
        pix_count <= '0;
      else if (pop && (gen_mem[rd_ptr] == line_gen))
        pix_count <= sat_inc16(pix_count);

      if (start_acc)
        clip_count <= '0;
      else if (clipped && (gen_p1 == line_gen))
        clip_count <= sat_inc8(clip_count);

      case (state)
        S_IDLE:    if (start_acc) state <= done_mark ? S_DRAIN : S_COLLECT;
        S_COLLECT: if (beat && done_mark) state <= S_DRAIN;
        S_DRAIN:   if (!vld_p1 && fifo_empty) state <= S_DONE;
        default:   state <= S_IDLE;
      endcase
    end
  end
endmodule
